// File: rtl/bound_flasher.sv
// ---------------------------------------------------------------------------
// bound_flasher
//
// 16-LED sweep controller. A sampled `flick` starts a fixed up/down sweep over
// bound points 0, 5, 10 and 15. While a sweep is rising, `flick` at a bound
// point kicks the sweep back down to the previous lower bound.
//
// Ports
//   clk   : in  1  - single clock, all state changes on the rising edge
//   rst   : in  1  - synchronous reset, active low
//   flick : in  1  - start / kickback request, sampled as a level
//   LEDs  : out 16 - LED drive, thermometer code of the lit count
//
// Internal state is the FSM state plus the lit count n (0..16). LEDs[i] is on
// when i < n, decoded straight from the register, so flick never reaches the
// outputs combinationally. The state register `state_q` is the debug view of
// the FSM.
// ---------------------------------------------------------------------------
module bound_flasher (
  input  logic        clk,
  input  logic        rst,
  input  logic        flick,
  output logic [15:0] LEDs
);

  typedef enum logic [2:0] {
    INIT        = 3'd0,
    ON_0_TO_10  = 3'd1,
    KICK_TO_0   = 3'd2,
    OFF_10_TO_5 = 3'd3,
    ON_5_TO_15  = 3'd4,
    KICK_TO_5   = 3'd5,
    OFF_15_TO_0 = 3'd6
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [4:0] n_q;
  logic [4:0] n_d;

  // Kickback points: LED5 just lit (n = 6) or LED10 just lit (n = 11).
  logic at_kick_point;
  assign at_kick_point = (n_q == 5'd6) || (n_q == 5'd11);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      n_q     <= 5'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    unique case (state_q)
      INIT: begin
        n_d = 5'd0;
        if (flick) begin
          state_d = ON_0_TO_10;
          n_d     = 5'd1;
        end
      end

      // Rising to ceiling 11. Kickback is checked before the ceiling so a
      // flick at n = 11 wins over the normal turn-around.
      ON_0_TO_10: begin
        if (flick && at_kick_point) begin
          state_d = KICK_TO_0;
          n_d     = n_q - 5'd1;
        end else if (n_q >= 5'd11) begin
          state_d = OFF_10_TO_5;
          n_d     = 5'd10;
        end else begin
          n_d = n_q + 5'd1;
        end
      end

      // Falling to floor 0; the floor value is held for one edge, then the
      // sweep restarts from the bottom.
      KICK_TO_0: begin
        if (n_q > 5'd0) begin
          n_d = n_q - 5'd1;
        end else begin
          state_d = ON_0_TO_10;
          n_d     = 5'd1;
        end
      end

      // Both fall to floor 5 and resume rising toward 16.
      OFF_10_TO_5, KICK_TO_5: begin
        if (n_q > 5'd5) begin
          n_d = n_q - 5'd1;
        end else begin
          state_d = ON_5_TO_15;
          n_d     = 5'd6;
        end
      end

      ON_5_TO_15: begin
        if (flick && at_kick_point) begin
          state_d = KICK_TO_5;
          n_d     = n_q - 5'd1;
        end else if (n_q >= 5'd16) begin
          state_d = OFF_15_TO_0;
          n_d     = 5'd15;
        end else begin
          n_d = n_q + 5'd1;
        end
      end

      OFF_15_TO_0: begin
        if (n_q > 5'd0) begin
          n_d = n_q - 5'd1;
        end else begin
          state_d = INIT;
          n_d     = 5'd0;
        end
      end

      // Unused encoding: fall back to idle with all LEDs off.
      default: begin
        state_d = INIT;
        n_d     = 5'd0;
      end
    endcase
  end

  // Thermometer decode of the lit count.
  always_comb begin
    LEDs = '0;
    for (int i = 0; i < 16; i++) begin
      LEDs[i] = (5'(i) < n_q);
    end
  end

endmodule

// File: tb/tb_bound_flasher.sv
// ---------------------------------------------------------------------------
// tb_bound_flasher
//
// Directed bench for bound_flasher. Each tick drives rst/flick, clocks one
// rising edge and compares LEDs against the thermometer code of the lit count
// worked out by hand for that edge.
// ---------------------------------------------------------------------------
module tb_bound_flasher;

  logic        clk;
  logic        rst;
  logic        flick;
  logic [15:0] leds;

  int checks   = 0;
  int failures = 0;
  int edge_num = 0;

  bound_flasher dut (
    .clk   (clk),
    .rst   (rst),
    .flick (flick),
    .LEDs  (leds)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] thermo(input int n);
    logic [16:0] t;
    t = (17'h1 << n) - 17'h1;
    return t[15:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h expected=%h", tag, edge_num, got, exp);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic tick(input string tag, input logic r, input logic f,
                      input int exp_n);
    rst   = r;
    flick = f;
    @(posedge clk);
    #1;
    edge_num++;
    check(tag, leds, thermo(exp_n));
  endtask

  // Edges with flick low where n walks from `from` to `to` inclusive.
  task automatic ramp(input string tag, input int from, input int to);
    if (from <= to) begin
      for (int i = from; i <= to; i++) tick(tag, 1'b1, 1'b0, i);
    end else begin
      for (int i = from; i >= to; i--) tick(tag, 1'b1, 1'b0, i);
    end
  endtask

  initial begin
    rst   = 1'b0;
    flick = 1'b0;

    // Reset holds LEDs dark even with flick asserted.
    tick("reset_flick", 1'b0, 1'b1, 0);
    tick("reset_flick", 1'b0, 1'b1, 0);
    tick("reset_release", 1'b1, 1'b0, 0);
    tick("reset_release", 1'b1, 1'b0, 0);

    // Normal run: start edge is edge 1, INIT again at edge 45.
    edge_num = 0;
    tick("norm_start", 1'b1, 1'b1, 1);
    ramp("norm_up11", 2, 11);
    ramp("norm_down5", 10, 5);
    ramp("norm_up16", 6, 16);
    ramp("norm_down0", 15, 0);
    tick("norm_init", 1'b1, 1'b0, 0);
    tick("norm_idle", 1'b1, 1'b0, 0);

    // Kickback at LED5 in the first rising leg.
    tick("k0_start", 1'b1, 1'b1, 1);
    ramp("k0_up6", 2, 6);
    tick("k0_kick6", 1'b1, 1'b1, 5);
    ramp("k0_down0", 4, 0);
    tick("k0_restart", 1'b1, 1'b0, 1);
    // Kickback at LED10 beats the ceiling turn-around: falls to 0, not 5.
    ramp("k0_up11", 2, 11);
    tick("k0_kick11", 1'b1, 1'b1, 10);
    ramp("k0_down0b", 9, 0);
    tick("k0_restart2", 1'b1, 1'b0, 1);

    // Kickback in the second rising leg.
    ramp("k5_up11", 2, 11);
    ramp("k5_down5", 10, 5);
    ramp("k5_up11b", 6, 11);
    tick("k5_kick11", 1'b1, 1'b1, 10);
    ramp("k5_down5b", 9, 5);
    tick("k5_rise6", 1'b1, 1'b0, 6);
    // Flick held at n = 6 oscillates 5,6,5,6 ...
    tick("k5_hold", 1'b1, 1'b1, 5);
    tick("k5_hold", 1'b1, 1'b1, 6);
    tick("k5_hold", 1'b1, 1'b1, 5);
    tick("k5_hold", 1'b1, 1'b1, 6);
    tick("k5_hold", 1'b1, 1'b1, 5);
    tick("k5_drop", 1'b1, 1'b0, 6);
    ramp("k5_up16", 7, 16);
    ramp("k5_down0", 15, 0);
    tick("k5_init", 1'b1, 1'b0, 0);

    // Flick pulses at non-kickback points and in OFF states change nothing.
    tick("ign_start", 1'b1, 1'b1, 1);
    ramp("ign_up3", 2, 3);
    tick("ign_n3", 1'b1, 1'b1, 4);
    ramp("ign_up11", 5, 11);
    tick("ign_off_a", 1'b1, 1'b0, 10);
    tick("ign_off_b", 1'b1, 1'b1, 9);
    ramp("ign_down5", 8, 5);
    tick("ign_floor5", 1'b1, 1'b1, 6);
    ramp("ign_up8", 7, 8);
    tick("ign_n8", 1'b1, 1'b1, 9);
    ramp("ign_up14", 10, 14);
    tick("ign_n14", 1'b1, 1'b1, 15);
    tick("ign_top", 1'b1, 1'b0, 16);
    tick("ign_n16", 1'b1, 1'b1, 15);
    ramp("ign_down10", 14, 10);
    tick("ign_off15", 1'b1, 1'b1, 9);
    ramp("ign_down0", 8, 0);
    tick("ign_last", 1'b1, 1'b1, 0);
    tick("ign_init", 1'b1, 1'b0, 0);

    // Reset mid-sweep at LEDs = 0x0FFF, then a clean restart.
    tick("mid_start", 1'b1, 1'b1, 1);
    ramp("mid_up11", 2, 11);
    ramp("mid_down5", 10, 5);
    ramp("mid_up12", 6, 12);
    tick("mid_reset", 1'b0, 1'b1, 0);
    tick("mid_idle", 1'b1, 1'b0, 0);
    tick("mid_restart", 1'b1, 1'b1, 1);
    tick("mid_rise", 1'b1, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
